// File: rtl/boxhead_pkg.sv
// Shared types, defaults and helpers for the enemy manager and the sprite movers.
package boxhead_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SNAP,
    SCAN,
    DONE,
    OVER
  } state_e;

  localparam int COORD_W_DEF        = 9;
  localparam int HIT_R_DEF          = 8;
  localparam int CONTACT_R_DEF      = 10;
  localparam int RESPAWN_FRAMES_DEF = 120;
  localparam int PLAYER_HP_DEF      = 5;
  localparam int INVULN_FRAMES_DEF  = 60;

  // Distances are evaluated at this width so any coordinate width up to 16 fits.
  localparam int ABS_W = 16;

  typedef logic [COORD_W_DEF-1:0] coord_t;

  function automatic logic [ABS_W-1:0] abs_diff(input logic [ABS_W-1:0] a,
                                                input logic [ABS_W-1:0] b);
    logic signed [ABS_W:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    abs_diff = d[ABS_W] ? ABS_W'(-d) : d[ABS_W-1:0];
  endfunction

endpackage

// File: rtl/frame_sync.sv
// Brings an asynchronous frame strobe into the clock domain and emits a
// one-cycle pulse on each rising edge, three cycles after the input rises.
module frame_sync (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic async_i,
  output logic tick_o
);

  logic s1_q, s2_q, prev_q, tick_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      s1_q   <= async_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
      tick_q <= s2_q & ~prev_q;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/enemy_manager.sv
// Scans all enemies once per frame: attack kills, player contact damage,
// respawn timers, score, player HP with invulnerability, and game over.
module enemy_manager
  import boxhead_pkg::*;
#(
  parameter int ENEMY_NUM      = 4,
  parameter int COORD_W        = COORD_W_DEF,
  parameter int HIT_R          = HIT_R_DEF,
  parameter int CONTACT_R      = CONTACT_R_DEF,
  parameter int RESPAWN_FRAMES = RESPAWN_FRAMES_DEF,
  parameter int PLAYER_HP      = PLAYER_HP_DEF,
  parameter int INVULN_FRAMES  = INVULN_FRAMES_DEF,
  parameter int SCORE_W        = 16,
  localparam int HP_W          = $clog2(PLAYER_HP + 1)
) (
  input  logic                           Clk,
  input  logic                           Reset_n,
  input  logic                           frame_clk,
  input  logic                           Attack_On,
  input  logic [COORD_W-1:0]             Attack_X,
  input  logic [COORD_W-1:0]             Attack_Y,
  input  logic [COORD_W-1:0]             Player_X,
  input  logic [COORD_W-1:0]             Player_Y,
  input  logic [ENEMY_NUM*COORD_W-1:0]   Enemy_X,
  input  logic [ENEMY_NUM*COORD_W-1:0]   Enemy_Y,
  output logic [ENEMY_NUM-1:0]           Enemy_Alive,
  output logic [SCORE_W-1:0]             Score,
  output logic [HP_W-1:0]                Player_HP,
  output logic                           Game_Over,
  output logic                           Frame_Done
);

  localparam int RSP_W = $clog2(RESPAWN_FRAMES + 1);
  localparam int INV_W = $clog2(INVULN_FRAMES + 1);
  localparam int IDX_W = (ENEMY_NUM > 1) ? $clog2(ENEMY_NUM) : 1;

  logic                 frame_tick;
  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [ENEMY_NUM-1:0] alive_q, alive_d;
  logic [RSP_W-1:0]     respawn_q [ENEMY_NUM];
  logic [RSP_W-1:0]     respawn_d [ENEMY_NUM];
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [HP_W-1:0]      hp_q, hp_d;
  logic [INV_W-1:0]     inv_q, inv_d;
  logic                 dmg_q, dmg_d;
  logic                 atk_on_q, atk_on_d;
  logic [COORD_W-1:0]   atk_x_q, atk_x_d, atk_y_q, atk_y_d;
  logic [COORD_W-1:0]   pl_x_q, pl_x_d, pl_y_q, pl_y_d;

  logic [COORD_W-1:0]   cur_x, cur_y;
  logic [ABS_W-1:0]     adx, ady, pdx, pdy;
  logic                 hit, contact;

  frame_sync u_frame_sync (
    .clk_i   (Clk),
    .rst_n_i (Reset_n),
    .async_i (frame_clk),
    .tick_o  (frame_tick)
  );

  // Live enemy position is compared against the frame's snapshot values.
  assign cur_x   = Enemy_X[int'(idx_q)*COORD_W +: COORD_W];
  assign cur_y   = Enemy_Y[int'(idx_q)*COORD_W +: COORD_W];
  assign adx     = abs_diff(ABS_W'(cur_x), ABS_W'(atk_x_q));
  assign ady     = abs_diff(ABS_W'(cur_y), ABS_W'(atk_y_q));
  assign pdx     = abs_diff(ABS_W'(cur_x), ABS_W'(pl_x_q));
  assign pdy     = abs_diff(ABS_W'(cur_y), ABS_W'(pl_y_q));
  assign hit     = atk_on_q && (adx <= ABS_W'(HIT_R)) && (ady <= ABS_W'(HIT_R));
  assign contact = (pdx <= ABS_W'(CONTACT_R)) && (pdy <= ABS_W'(CONTACT_R));

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    alive_d   = alive_q;
    respawn_d = respawn_q;
    score_d   = score_q;
    hp_d      = hp_q;
    inv_d     = inv_q;
    dmg_d     = dmg_q;
    atk_on_d  = atk_on_q;
    atk_x_d   = atk_x_q;
    atk_y_d   = atk_y_q;
    pl_x_d    = pl_x_q;
    pl_y_d    = pl_y_q;

    case (state_q)
      IDLE: begin
        if (frame_tick) state_d = SNAP;
      end
      SNAP: begin
        atk_on_d = Attack_On;
        atk_x_d  = Attack_X;
        atk_y_d  = Attack_Y;
        pl_x_d   = Player_X;
        pl_y_d   = Player_Y;
        dmg_d    = 1'b0;
        idx_d    = '0;
        state_d  = SCAN;
      end
      SCAN: begin
        if (alive_q[idx_q]) begin
          if (hit) begin
            alive_d[idx_q]   = 1'b0;
            respawn_d[idx_q] = RSP_W'(RESPAWN_FRAMES);
            if (score_q != '1) score_d = score_q + SCORE_W'(1);
          end else if (contact && inv_q == '0 && !dmg_q && hp_q != '0) begin
            hp_d  = hp_q - HP_W'(1);
            inv_d = INV_W'(INVULN_FRAMES);
            dmg_d = 1'b1;
          end
        end else if (respawn_q[idx_q] <= RSP_W'(1)) begin
          respawn_d[idx_q] = '0;
          alive_d[idx_q]   = 1'b1;
        end else begin
          respawn_d[idx_q] = respawn_q[idx_q] - RSP_W'(1);
        end
        if (idx_q == IDX_W'(ENEMY_NUM - 1)) state_d = DONE;
        else idx_d = idx_q + IDX_W'(1);
      end
      DONE: begin
        // A window started during this frame's scan keeps its full length.
        if (inv_q != '0 && !dmg_q) inv_d = inv_q - INV_W'(1);
        state_d = (hp_q == '0) ? OVER : IDLE;
      end
      OVER: begin
        state_d = OVER;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      alive_q   <= '1;
      respawn_q <= '{default: '0};
      score_q   <= '0;
      hp_q      <= HP_W'(PLAYER_HP);
      inv_q     <= '0;
      dmg_q     <= 1'b0;
      atk_on_q  <= 1'b0;
      atk_x_q   <= '0;
      atk_y_q   <= '0;
      pl_x_q    <= '0;
      pl_y_q    <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      alive_q   <= alive_d;
      respawn_q <= respawn_d;
      score_q   <= score_d;
      hp_q      <= hp_d;
      inv_q     <= inv_d;
      dmg_q     <= dmg_d;
      atk_on_q  <= atk_on_d;
      atk_x_q   <= atk_x_d;
      atk_y_q   <= atk_y_d;
      pl_x_q    <= pl_x_d;
      pl_y_q    <= pl_y_d;
    end
  end

  assign Enemy_Alive = alive_q;
  assign Score       = score_q;
  assign Player_HP   = hp_q;
  assign Game_Over   = (state_q == OVER);
  assign Frame_Done  = (state_q == DONE);

endmodule

// File: tb/tb_enemy_manager.sv
// Directed bench for enemy_manager: kills, respawn, contact damage with
// invulnerability, game over freeze and score saturation (2-bit build).
module tb_enemy_manager;

  logic        Clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_clk = 1'b0;
  logic        atk_on = 1'b0;
  logic [8:0]  atk_x = '0, atk_y = '0, pl_x = '0, pl_y = '0;
  logic [35:0] ex = '0, ey = '0;
  logic [3:0]  alive;
  logic [15:0] score;
  logic [2:0]  hp;
  logic        game_over, frame_done;

  logic [35:0] ex2 = '0, ey2 = '0;
  logic [3:0]  alive2;
  logic [1:0]  score2;
  logic [2:0]  hp2;
  logic        game_over2, frame_done2;

  int n_tests = 0;
  int n_fail  = 0;
  int last_lat;
  logic fd_after;

  always #10 Clk = ~Clk;

  enemy_manager dut (
    .Clk(Clk), .Reset_n(rst_n), .frame_clk(frame_clk),
    .Attack_On(atk_on), .Attack_X(atk_x), .Attack_Y(atk_y),
    .Player_X(pl_x), .Player_Y(pl_y), .Enemy_X(ex), .Enemy_Y(ey),
    .Enemy_Alive(alive), .Score(score), .Player_HP(hp),
    .Game_Over(game_over), .Frame_Done(frame_done)
  );

  // Fast-respawn, 2-bit-score build: every enemy sits on a live attack.
  enemy_manager #(.SCORE_W(2), .RESPAWN_FRAMES(2)) dut2 (
    .Clk(Clk), .Reset_n(rst_n), .frame_clk(frame_clk),
    .Attack_On(1'b1), .Attack_X(9'd200), .Attack_Y(9'd200),
    .Player_X(9'd10), .Player_Y(9'd10), .Enemy_X(ex2), .Enemy_Y(ey2),
    .Enemy_Alive(alive2), .Score(score2), .Player_HP(hp2),
    .Game_Over(game_over2), .Frame_Done(frame_done2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_enemy(input int i, input logic [8:0] x, input logic [8:0] y);
    ex[i*9 +: 9] = x;
    ey[i*9 +: 9] = y;
  endtask

  task automatic do_frame(input bit exp_done);
    int n;
    bit seen;
    @(posedge Clk); #1 frame_clk = 1'b1;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge Clk); #1;
      n++;
      if (frame_done) seen = 1'b1;
    end
    chk("frame_done_seen", 32'(seen), 32'(exp_done));
    last_lat = n;
    @(posedge Clk); #1 fd_after = frame_done;
    frame_clk = 1'b0;
    repeat (4) @(posedge Clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      ex2[i*9 +: 9] = 9'd200;
      ey2[i*9 +: 9] = 9'd200;
    end
    pl_x = 9'd300; pl_y = 9'd200;
    atk_x = 9'd100; atk_y = 9'd100;
    set_enemy(0, 9'd10, 9'd10);
    set_enemy(1, 9'd40, 9'd10);
    set_enemy(2, 9'd70, 9'd10);
    set_enemy(3, 9'd250, 9'd20);

    repeat (3) @(posedge Clk);
    #1;
    chk("rst_alive", 32'(alive), 32'hF);
    chk("rst_score", 32'(score), 0);
    chk("rst_hp", 32'(hp), 5);
    chk("rst_game_over", 32'(game_over), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    @(posedge Clk); #1 rst_n = 1'b1;

    // Idle frame: 3 sync cycles to frame_tick, then ENEMY_NUM+2 to Frame_Done.
    do_frame(1);
    chk("t1_latency", 32'(last_lat), 9);
    chk("t1_fd_pulse_width", 32'(fd_after), 0);
    chk("t1_alive", 32'(alive), 32'hF);
    chk("t1_score", 32'(score), 0);
    chk("t1_hp", 32'(hp), 5);
    chk("sat_score_frame1", 32'(score2), 3);
    chk("sat_alive_frame1", 32'(alive2), 0);

    // Attack at (100,100) kills enemy 2 at (106,93); respawn 120 frames later.
    atk_on = 1'b1;
    set_enemy(2, 9'd106, 9'd93);
    do_frame(1);
    chk("t2_alive", 32'(alive), 32'b1011);
    chk("t2_score", 32'(score), 1);
    atk_on = 1'b0;
    repeat (119) do_frame(1);
    chk("t2_alive_frame119", 32'(alive), 32'b1011);
    do_frame(1);
    chk("t2_alive_frame120", 32'(alive), 32'hF);

    // Enemy 1 in both hit and contact range: kill wins, no damage.
    // Enemy 2 exactly on the hit box corner dies; enemy 0 one pixel out survives.
    pl_x = 9'd150; pl_y = 9'd150;
    atk_on = 1'b1; atk_x = 9'd160; atk_y = 9'd150;
    set_enemy(0, 9'd169, 9'd150);
    set_enemy(1, 9'd155, 9'd150);
    set_enemy(2, 9'd168, 9'd142);
    do_frame(1);
    chk("t4_alive", 32'(alive), 32'b1001);
    chk("t4_score", 32'(score), 3);
    chk("t4_hp", 32'(hp), 5);

    // Enemies 0 and 3 both touch the player: one damage, then 60 frames invulnerable.
    atk_on = 1'b0;
    pl_x = 9'd50; pl_y = 9'd50;
    set_enemy(0, 9'd50, 9'd50);
    set_enemy(1, 9'd250, 9'd200);
    set_enemy(2, 9'd250, 9'd200);
    set_enemy(3, 9'd50, 9'd50);
    do_frame(1);
    chk("t3_hp_first", 32'(hp), 4);
    chk("t3_alive", 32'(alive), 32'b1001);
    repeat (60) do_frame(1);
    chk("t3_hp_invuln", 32'(hp), 4);
    do_frame(1);
    chk("t3_hp_frame61", 32'(hp), 3);

    for (int k = 0; k < 3; k++) begin
      repeat (60) do_frame(1);
      chk("t5_hp_hold", 32'(hp), 32'(3 - k));
      do_frame(1);
      chk("t5_hp_drop", 32'(hp), 32'(2 - k));
    end
    chk("t5_game_over", 32'(game_over), 1);
    chk("t5_alive_at_over", 32'(alive), 32'hF);

    // Frozen: an attack on enemies 0/3 must neither kill nor score, and no Frame_Done.
    atk_on = 1'b1; atk_x = 9'd50; atk_y = 9'd50;
    do_frame(0);
    chk("over_alive_frozen", 32'(alive), 32'hF);
    chk("over_score_frozen", 32'(score), 3);
    chk("over_hp", 32'(hp), 0);
    chk("over_sticky", 32'(game_over), 1);
    chk("sat_score_end", 32'(score2), 3);

    rst_n = 1'b0;
    #1;
    chk("rst2_game_over", 32'(game_over), 0);
    chk("rst2_hp", 32'(hp), 5);
    chk("rst2_score", 32'(score), 0);
    chk("rst2_alive", 32'(alive), 32'hF);
    chk("rst2_score_sat", 32'(score2), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/enemy_manager.md
Name: enemy_manager

Overview:
- Parametrised replacement for the per-enemy collision/alive-flag instances in the top level.
- One block manages ENEMY_NUM enemies. On each frame it scans them sequentially, one per Clk cycle.
- Per frame it resolves attack kills and player contact damage, and runs per-enemy respawn timers, score, player HP with an invulnerability window, and game over.
- Sits between the player/attack/enemy movers and the color mapper/HEX display. Clocked by the 50 MHz Clk; frame timing comes from VGA_VS.

Parameters:
- ENEMY_NUM, 4, number of enemies managed (1..16)
- COORD_W, 9, coordinate width in pixels (320x240 space)
- HIT_R, 8, attack hit half-box: hit when |dx|<=HIT_R and |dy|<=HIT_R
- CONTACT_R, 10, player contact half-box, same rule
- RESPAWN_FRAMES, 120, frames an enemy stays dead
- PLAYER_HP, 5, starting hit points
- INVULN_FRAMES, 60, frames of invulnerability after damage
- SCORE_W, 16, score counter width

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous active-low reset
- frame_clk  in  1  VGA_VS, asynchronous to Clk
- Attack_On  in  1  attack sprite active
- Attack_X, Attack_Y  in  COORD_W each  attack position
- Player_X, Player_Y  in  COORD_W each  player position
- Enemy_X, Enemy_Y  in  ENEMY_NUM*COORD_W each  packed enemy positions; enemy i at [i*COORD_W +: COORD_W]
- Enemy_Alive  out  ENEMY_NUM  alive bitmap
- Score  out  SCORE_W  kill count
- Player_HP  out  $clog2(PLAYER_HP+1)  remaining HP
- Game_Over  out  1  sticky end-of-game flag
- Frame_Done  out  1  one-cycle pulse when a frame's scan completes

Behaviour:
- Reset values (async, Reset_n low):
  - Enemy_Alive all 1; Score 0; Player_HP=PLAYER_HP; Game_Over 0; Frame_Done 0.
  - All respawn counters 0; invulnerability counter 0; FSM in IDLE; sync flops 0.
- frame_clk synchronisation: 2-flop synchroniser followed by a rising-edge detector. frame_tick is a 1-cycle pulse, 3 cycles after the frame_clk rise.
- FSM states: IDLE, SNAP, SCAN, DONE, OVER.
- IDLE: on frame_tick go to SNAP.
- SNAP (1 cycle):
  - Register Attack_On/X/Y and Player_X/Y into snapshot regs.
  - Clear damage_taken flag; idx=0.
- SCAN (ENEMY_NUM cycles, idx 0..ENEMY_NUM-1). For enemy idx, use live Enemy_X/Y[idx] and the snapshot values. Differences are computed as signed COORD_W+1 bit values, then absolute value.
  - Alive and attack hit (snap Attack_On=1): clear alive bit; respawn counter=RESPAWN_FRAMES; Score+1, saturating at all-ones. Kill has priority over contact for the same enemy.
  - Alive, no hit, contact, invulnerability counter==0, damage_taken==0, Player_HP>0: Player_HP-1; invulnerability counter=INVULN_FRAMES; set damage_taken. At most one damage per frame; the lowest idx wins.
  - Dead: decrement respawn counter. When it decrements from 1 to 0, set the alive bit. An enemy killed in this frame is not decremented until the next frame.
  - One attack may kill multiple enemies in the same frame.
  - Register updates are visible the cycle after the enemy's scan cycle.
  - After idx=ENEMY_NUM-1, go to DONE.
- DONE (1 cycle):
  - Frame_Done=1.
  - Decrement the invulnerability counter if >0 and not set this frame.
  - If Player_HP==0, go to OVER; else go to IDLE.
- OVER:
  - Game_Over=1 (sticky); Enemy_Alive, Score and HP frozen.
  - frame_tick ignored; exit only via Reset_n.
- Latency: Frame_Done is asserted exactly ENEMY_NUM+2 cycles after frame_tick.
- frame_tick while not in IDLE is ignored. Not reachable in practice, since a scan is far shorter than a frame.
- Reset mid-scan: partial updates are discarded; all state returns to reset values.

Decomposition:
- Shared package boxhead_pkg holds:
  - state enum (IDLE, SNAP, SCAN, DONE, OVER)
  - coordinate typedef (logic [COORD_W-1:0])
  - abs-difference function
  - default constants for HIT_R, CONTACT_R, RESPAWN_FRAMES, PLAYER_HP, INVULN_FRAMES
- Sub-module frame_sync: 2-flop synchroniser plus rising-edge pulse. Also reusable for the movers.

Test Plan:
- Reset then one frame_clk rise, no overlaps -> Frame_Done pulses once at ENEMY_NUM+2 cycles after frame_tick; Enemy_Alive=4'b1111, Score=0, Player_HP=5.
- Attack_On=1 at (100,100), enemy 2 at (106,93) -> after scan Enemy_Alive=4'b1011, Score=1. Enemy 2 alive again exactly 120 frames later.
- Enemies 0 and 3 both at the player position (50,50), Attack_On=0 -> Player_HP=4 (single damage). Next 60 frames no further damage; HP drops to 3 on frame 61.
- Enemy 1 within both HIT_R and CONTACT_R with Attack_On=1 -> enemy killed, Score+1, Player_HP unchanged.
- Five separated contact events -> Player_HP reaches 0, Game_Over=1. Further frames produce no Frame_Done, and Score/Alive are frozen.
- Score preloaded near saturation via SCORE_W=2 build, 5 kills -> Score stops at 3.
